// File: rtl/hilo_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit_pkg
//   Shared definitions for the iterative HI/LO multiply/divide unit:
//   default widths, the MULT/MULTU/DIV/DIVU opcode encoding, the FSM state
//   encoding and small opcode-decode helpers.
// ---------------------------------------------------------------------------
package hilo_muldiv_unit_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } state_e;

   // Bit 1 of the opcode selects divide, bit 0 selects the unsigned variant.
   function automatic logic op_is_div(input op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input op_e op);
      return ~op[0];
   endfunction

endpackage : hilo_muldiv_unit_pkg

// File: rtl/hilo_muldiv_unit_muldiv_iter_core.sv
// ---------------------------------------------------------------------------
// muldiv_iter_core
//   Purely combinational next-step logic for one radix-2 iteration.
//   Multiply: shift-add on the {part_hi, part_lo} accumulator; part_lo holds
//             the remaining multiplier bits, operand is the multiplicand.
//   Divide:   restoring division; part_hi is the running remainder, part_lo
//             shifts dividend bits out and quotient bits in, operand is the
//             divisor.
// Ports
//   is_div   in   1      select divide step (else multiply step)
//   part_hi  in   WIDTH  upper accumulator / remainder
//   part_lo  in   WIDTH  lower accumulator / dividend-quotient shift
//   operand  in   WIDTH  multiplicand or divisor magnitude
//   next_hi  out  WIDTH  part_hi after this step
//   next_lo  out  WIDTH  part_lo after this step
// ---------------------------------------------------------------------------
module muldiv_iter_core
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] part_hi,
   input  logic [WIDTH-1:0] part_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH:0]   sum;    // multiply: upper half plus optional addend, with carry
   logic [WIDTH:0]   trial;  // divide: 33-bit partial remainder after shifting in a dividend bit
   logic             fits;   // divide: divisor can be subtracted this step
   logic [WIDTH-1:0] diff;

   assign sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
   assign trial = {part_hi, part_lo[WIDTH-1]};
   assign fits  = (trial >= {1'b0, operand});
   // When the subtraction is taken the result is below the divisor, so the
   // low WIDTH bits of the difference are exact.
   assign diff  = trial[WIDTH-1:0] - operand;

   always_comb begin
      if (is_div) begin
         next_hi = fits ? diff : trial[WIDTH-1:0];
         next_lo = {part_lo[WIDTH-2:0], fits};
      end else begin
         next_hi = sum[WIDTH:1];
         next_lo = {sum[0], part_lo[WIDTH-1:1]};
      end
   end

endmodule : muldiv_iter_core

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//   Iterative MIPS MULT/MULTU/DIV/DIVU unit with the architectural HI/LO
//   registers. Operands arrive from the register file read ports; HI/LO feed
//   the MFHI/MFLO path. MTHI/MTLO write HI/LO directly.
//   One op takes 33 edges from the Start edge to Done: WIDTH iteration edges
//   followed by a sign-fix edge that writes HI/LO.
// Ports
//   Clk        in   1      rising-edge clock
//   Reset      in   1      synchronous, active-high; aborts an op in flight
//   Start      in   1      launch op; sampled only in IDLE
//   Op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   OperandA   in   WIDTH  multiplicand / dividend
//   OperandB   in   WIDTH  multiplier / divisor
//   WriteHi    in   1      MTHI strobe
//   WriteLo    in   1      MTLO strobe
//   WriteData  in   WIDTH  MTHI/MTLO data
//   Busy       out  1      op in flight
//   Done       out  1      one-cycle pulse; Hi/Lo hold the new result
//   Hi         out  WIDTH  remainder / product upper half
//   Lo         out  WIDTH  quotient / product lower half
// ---------------------------------------------------------------------------
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             WriteHi,
   input  logic             WriteLo,
   input  logic [WIDTH-1:0] WriteData,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   state_e           state, next_state;
   logic             load, step, fix;

   logic [CNT_W-1:0] count;
   logic             is_div_q;    // latched op is a divide
   logic             neg_q;       // negate product / quotient at fix
   logic             neg_r;       // negate remainder at fix
   logic             div_zero;    // divisor was zero
   logic [WIDTH-1:0] step_opnd;   // multiplicand or divisor magnitude
   logic [WIDTH-1:0] part_hi, part_lo;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q;

   // ---- operand decode at the Start edge ----
   op_e              op_in;
   logic             op_div, op_signed, sign_a, sign_b;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign op_in     = op_e'(Op);
   assign op_div    = op_is_div(op_in);
   assign op_signed = op_is_signed(op_in);
   assign sign_a    = op_signed & OperandA[WIDTH-1];
   assign sign_b    = op_signed & OperandB[WIDTH-1];
   assign mag_a     = sign_a ? -OperandA : OperandA;
   assign mag_b     = sign_b ? -OperandB : OperandB;

   // ---- per-step datapath ----
   logic [WIDTH-1:0] next_hi, next_lo;

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .is_div  (is_div_q),
      .part_hi (part_hi),
      .part_lo (part_lo),
      .operand (step_opnd),
      .next_hi (next_hi),
      .next_lo (next_lo)
   );

   // ---- sign correction applied on the fix edge ----
   logic [2*WIDTH-1:0] product, product_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix, fix_hi, fix_lo;

   assign product     = {part_hi, part_lo};
   assign product_fix = neg_q ? -product : product;
   // Divide by zero leaves the dividend in the remainder path; re-applying
   // the dividend sign restores OperandA exactly, so only Lo is overridden.
   assign quot_fix    = div_zero ? {WIDTH{1'b1}} : (neg_q ? -part_lo : part_lo);
   assign rem_fix     = neg_r ? -part_hi : part_hi;
   assign fix_hi      = is_div_q ? rem_fix  : product_fix[2*WIDTH-1:WIDTH];
   assign fix_lo      = is_div_q ? quot_fix : product_fix[WIDTH-1:0];

   // ---- FSM next-state / control ----
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned and no latch is inferred.
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      fix        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (Start) begin
               next_state = S_CALC;
               load       = 1'b1;
            end
         end
         S_CALC: begin
            step = 1'b1;
            if (count == CNT_W'(WIDTH-1)) next_state = S_FIX;
         end
         S_FIX: begin
            fix        = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // ---- state, datapath and HI/LO registers ----
   always_ff @(posedge Clk) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the values from before this edge regardless of order.
      if (Reset) begin
         state     <= S_IDLE;
         count     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div_zero  <= 1'b0;
         step_opnd <= '0;
         part_hi   <= '0;
         part_lo   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= next_state;
         done_q <= fix;

         if (load) begin
            count     <= '0;
            is_div_q  <= op_div;
            neg_q     <= sign_a ^ sign_b;
            neg_r     <= op_div & sign_a;
            div_zero  <= op_div & (OperandB == '0);
            step_opnd <= op_div ? mag_b : mag_a;
            part_hi   <= '0;
            part_lo   <= op_div ? mag_a : mag_b;
         end else if (step) begin
            count   <= count + 1'b1;
            part_hi <= next_hi;
            part_lo <= next_lo;
         end

         // The op result takes priority over an MTHI/MTLO on the same edge.
         if (fix) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end else begin
            if (WriteHi) hi_q <= WriteData;
            if (WriteLo) lo_q <= WriteData;
         end
      end
   end

   assign Busy = (state != S_IDLE);
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule : hilo_muldiv_unit

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//   Directed, table-driven bench for hilo_muldiv_unit plus hand-written
//   sequences for ignored Start, MTHI/MTLO timing and mid-op reset.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] OperandA, OperandB;
   logic        WriteHi, WriteLo;
   logic [31:0] WriteData;
   logic        Busy, Done;
   logic [31:0] Hi, Lo;

   hilo_muldiv_unit #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Op        (Op),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .WriteHi   (WriteHi),
      .WriteLo   (WriteLo),
      .WriteData (WriteData),
      .Busy      (Busy),
      .Done      (Done),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive Start for one edge (E0); returns #1 after E0 with operands scrambled.
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic done_at_launch);
      @(negedge Clk);
      done_at_launch = Done;
      Start    = 1'b1;
      Op       = op;
      OperandA = a;
      OperandB = b;
      @(posedge Clk); #1;
      Start    = 1'b0;
      Op       = ~op;
      OperandA = 32'hDEAD_BEEF;
      OperandB = 32'h0BAD_F00D;
   endtask

   // Wait (bounded) for Done, counting edges from first_edge and Busy samples.
   task automatic wait_done(input int first_edge, output int lat, output int busy_cnt);
      lat      = first_edge;
      busy_cnt = 0;
      while (Done !== 1'b1 && lat < 100) begin
         if (Busy === 1'b1) busy_cnt++;
         @(posedge Clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input vec_t v, input logic expect_done_at_launch);
      logic dl;
      int   lat, bc;
      launch(v.op, v.a, v.b, dl);
      if (expect_done_at_launch) check({v.name, "_launch_in_done_cycle"}, 64'(dl), 64'd1);
      wait_done(0, lat, bc);
      check({v.name, "_latency"}, 64'(lat), 64'd33);
      check({v.name, "_busy_cycles"}, 64'(bc), 64'd33);
      check({v.name, "_busy_clear"}, 64'(Busy), 64'd0);
      check({v.name, "_hi"}, 64'(Hi), 64'(v.exp_hi));
      check({v.name, "_lo"}, 64'(Lo), 64'(v.exp_lo));
   endtask

   initial begin
      logic dl;
      int   lat, bc, seen;

      Reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
      WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0;

      vecs[0]  = '{"mult_7x6",        OP_MULT,  32'd7,         32'd6,         32'h0000_0000, 32'd42};
      vecs[1]  = '{"mult_m3x5",       OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[2]  = '{"multu_max",       OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[3]  = '{"div_m7d2",        OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4]  = '{"divu_100d0",      OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
      vecs[5]  = '{"div_min_dm1",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[6]  = '{"div_7dm2",        OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[7]  = '{"divu_max_d10",    OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999};
      vecs[8]  = '{"mult_minxmin",    OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[9]  = '{"mult_m1xm1",      OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      vecs[10] = '{"div_m8d0",        OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
      vecs[11] = '{"multu_shift",     OP_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
      vecs[12] = '{"div_100d7",       OP_DIV,   32'd100,       32'd7,         32'd2,         32'd14};
      vecs[13] = '{"div_m100dm7",     OP_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};

      // ---- reset state ----
      repeat (2) @(posedge Clk);
      #1;
      check("reset_busy", 64'(Busy), 64'd0);
      check("reset_done", 64'(Done), 64'd0);
      check("reset_hi",   64'(Hi),   64'd0);
      check("reset_lo",   64'(Lo),   64'd0);
      @(negedge Clk) Reset = 1'b0;

      // ---- MTHI in IDLE, then MTHI+MTLO together ----
      @(negedge Clk);
      WriteHi = 1'b1; WriteData = 32'h0000_ABCD;
      @(posedge Clk); #1;
      WriteHi = 1'b0;
      check("mthi_idle_hi", 64'(Hi), 64'h0000_ABCD);
      check("mthi_idle_lo", 64'(Lo), 64'd0);
      @(negedge Clk);
      WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'h0000_1234;
      @(posedge Clk); #1;
      WriteHi = 1'b0; WriteLo = 1'b0;
      check("mthi_mtlo_hi", 64'(Hi), 64'h0000_1234);
      check("mthi_mtlo_lo", 64'(Lo), 64'h0000_1234);

      // ---- table: back-to-back ops, each launched while Done is high ----
      for (int i = 0; i < NVEC; i++) run_op(vecs[i], i > 0);

      // ---- Start pulsed again at E5 is ignored ----
      launch(OP_MULT, 32'd7, 32'd6, dl);
      repeat (4) @(posedge Clk);           // now past E4
      @(negedge Clk);
      Start = 1'b1; Op = OP_DIVU; OperandA = 32'd1; OperandB = 32'd1;
      @(posedge Clk); #1;                  // E5
      Start = 1'b0;
      check("restart_busy_e5", 64'(Busy), 64'd1);
      wait_done(5, lat, bc);
      check("restart_latency", 64'(lat), 64'd33);
      check("restart_hi", 64'(Hi), 64'd0);
      check("restart_lo", 64'(Lo), 64'd42);

      // ---- MTHI while busy shows next edge; strobes on FIX edge lose ----
      launch(OP_MULT, 32'd7, 32'd6, dl);
      repeat (2) @(posedge Clk);           // E2
      @(negedge Clk);
      WriteHi = 1'b1; WriteData = 32'h0000_5555;
      @(posedge Clk); #1;                  // E3
      WriteHi = 1'b0;
      check("mthi_busy_hi", 64'(Hi), 64'h0000_5555);
      repeat (29) @(posedge Clk);          // E32
      #1;
      check("fix_edge_no_done_e32", 64'(Done), 64'd0);
      @(negedge Clk);
      WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'h0000_7777;
      @(posedge Clk); #1;                  // E33
      WriteHi = 1'b0; WriteLo = 1'b0;
      check("fix_edge_done", 64'(Done), 64'd1);
      check("fix_edge_hi",   64'(Hi),   64'd0);
      check("fix_edge_lo",   64'(Lo),   64'd42);
      @(posedge Clk); #1;
      check("done_one_cycle", 64'(Done), 64'd0);

      // ---- Reset at E10 of a MULT aborts it ----
      launch(OP_MULT, 32'd3, 32'd3, dl);
      repeat (9) @(posedge Clk);           // E9
      @(negedge Clk) Reset = 1'b1;
      @(posedge Clk); #1;                  // E10
      check("abort_busy", 64'(Busy), 64'd0);
      check("abort_done", 64'(Done), 64'd0);
      check("abort_hi",   64'(Hi),   64'd0);
      check("abort_lo",   64'(Lo),   64'd0);
      @(negedge Clk) Reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge Clk); #1;
         if (Done === 1'b1) seen++;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      run_op('{"divu_9d4", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2}, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hilo_muldiv_unit
